debug_display: RTL



---
 rtl/debug_display.sv | 95 +++++++++
 1 files changed

// File: rtl/debug_display.sv
// Eight-digit hex seven-segment viewer for the processor debug buses.
// The shown value is snapshotted once per scan frame; freeze holds it.
module debug_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] program_counter,
  input  logic [31:0] write_data,
  input  logic [31:0] HI_out,
  input  logic [31:0] LO_out,
  input  logic [1:0]  sel,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [1:0]    r_sel_m, r_sel_s;
  logic          r_frz_m, r_frz_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_digit;
  logic [31:0]   r_snap;
  logic          r_chg;
  logic          w_tick, w_frame;
  logic [31:0]   w_src;
  logic [3:0]    w_nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign w_tick  = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_frame = w_tick && (r_digit == 3'd7);
  assign w_nib   = r_snap[4*r_digit +: 4];

  always_comb begin
    w_src = program_counter;
    case (r_sel_s)
      2'd1:    w_src = write_data;
      2'd2:    w_src = HI_out;
      2'd3:    w_src = LO_out;
      default: w_src = program_counter;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sel_m <= '0;
      r_sel_s <= '0;
      r_frz_m <= 1'b0;
      r_frz_s <= 1'b0;
      r_cnt   <= '0;
      r_digit <= '0;
      r_snap  <= '0;
      r_chg   <= 1'b0;
      an      <= 8'b1111_1110;
      seg     <= 7'b1000000;
      dp      <= 1'b1;
    end else begin
      r_sel_m <= sel;
      r_sel_s <= r_sel_m;
      r_frz_m <= freeze;
      r_frz_s <= r_frz_m;
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_digit <= r_digit + 3'd1;
      // Loading only at the frame boundary keeps all eight digits from one value.
      if (w_frame && !r_frz_s) begin
        r_snap <= w_src;
        r_chg  <= (w_src != r_snap);
      end
      an  <= ~(8'd1 << r_digit);
      seg <= hex7(w_nib);
      dp  <= ~((r_digit == 3'd0) && r_chg);
    end
  end
endmodule
